status_uart_reporter: RTL and testbench

Consumes the 3-bit system status code from the PIN verification FSM and reports each status change over a UART TX line as a fixed 6-byte ASCII message. It is the transmit end of the status path to the host terminal. The block contains change detection, a pending-update slot, a message ROM and an 8N1 serializer with a baud counter.

---
 rtl/status_uart_reporter.sv | 157 +++++++++++++++
 tb/tb_status_uart_reporter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/status_uart_reporter.sv
// Reports each change of the 3-bit status code as a 6-byte ASCII message on an 8N1 UART line.
// Updates that arrive mid-message collapse into one pending slot; only the latest status is sent.
module status_uart_reporter #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [2:0] i_status,
   input  logic       i_resend,
   output logic       o_tx,
   output logic       o_busy,
   output logic       o_msg_done
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [2:0]      r_status_q;
   logic            resend_q;
   logic [2:0]      last_sent_q, last_sent_d;
   logic [2:0]      msg_code_q, msg_code_d;
   logic            pending_q, pending_d;
   logic            rs_seen_q, rs_seen_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [2:0]      byte_q, byte_d;

   logic            changed;
   logic            baud_end;
   logic            serializing;
   logic [31:0]     word;
   logic [7:0]      cur_byte;

   assign changed     = (r_status_q != last_sent_q);
   assign baud_end    = (baud_q == BAUD_MAX);
   assign serializing = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         r_status_q  <= 3'd0;
         resend_q    <= 1'b0;
         last_sent_q <= 3'd0;
         msg_code_q  <= 3'd0;
         pending_q   <= 1'b0;
         rs_seen_q   <= 1'b0;
         baud_q      <= '0;
         bit_q       <= 3'd0;
         byte_q      <= 3'd0;
      end else begin
         state_q     <= state_d;
         r_status_q  <= i_status;
         resend_q    <= i_resend;
         last_sent_q <= last_sent_d;
         msg_code_q  <= msg_code_d;
         pending_q   <= pending_d;
         rs_seen_q   <= rs_seen_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         byte_q      <= byte_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      last_sent_d = last_sent_q;
      msg_code_d  = msg_code_q;
      pending_d   = pending_q;
      rs_seen_d   = rs_seen_q;
      baud_d      = baud_q;
      bit_d       = bit_q;
      byte_d      = byte_q;

      if (serializing) begin
         baud_d = baud_end ? '0 : baud_q + 1'b1;
         if (changed || resend_q) pending_d = 1'b1;
         if (resend_q)            rs_seen_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (changed || resend_q || pending_q) begin
               state_d     = S_START;
               baud_d      = '0;
               bit_d       = 3'd0;
               byte_d      = 3'd0;
               msg_code_d  = r_status_q;
               last_sent_d = r_status_q;
               pending_d   = 1'b0;
               rs_seen_d   = 1'b0;
            end
         end
         S_START: begin
            if (baud_end) begin
               state_d = S_DATA;
               bit_d   = 3'd0;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         S_STOP: begin
            if (baud_end) begin
               if (byte_q < 3'd5) begin
                  state_d = S_START;
                  byte_d  = byte_q + 3'd1;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            // A change that reverted to last_sent is dropped; a captured resend survives.
            pending_d = (pending_q && (changed || rs_seen_q)) || resend_q;
            rs_seen_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      case (msg_code_q)
         3'd0:    word = "IDLE";
         3'd1:    word = "OPEN";
         3'd2:    word = "ERR1";
         3'd3:    word = "ERR2";
         3'd4:    word = "LOCK";
         default: word = "????";
      endcase
      case (byte_q)
         3'd0:    cur_byte = word[31:24];
         3'd1:    cur_byte = word[23:16];
         3'd2:    cur_byte = word[15:8];
         3'd3:    cur_byte = word[7:0];
         3'd4:    cur_byte = 8'h0D;
         default: cur_byte = 8'h0A;
      endcase
   end

   always_comb begin
      o_busy     = serializing;
      o_msg_done = (state_q == S_DONE);
      case (state_q)
         S_START: o_tx = 1'b0;
         S_DATA:  o_tx = cur_byte[bit_q];
         default: o_tx = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_status_uart_reporter.sv
// Directed bench: expected message bytes go into a queue, a UART monitor decodes o_tx and checks them.
module tb_status_uart_reporter;
   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] status;
   logic       resend;
   logic       tx, busy, msg_done;

   int checks = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   int done_cnt = 0;
   int busy_total = 0;
   int busy_run = 0;
   int last_run = 0;
   int mon_frames = 0;

   logic [7:0] mon_byte;
   logic       mon_ok, mon_abort, mon_prev;
   logic [7:0] mon_exp;

   status_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_status(status), .i_resend(resend),
      .o_tx(tx), .o_busy(busy), .o_msg_done(msg_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_msg(input logic [47:0] m);
      for (int i = 5; i >= 0; i--) exp_q.push_back(m[i*8 +: 8]);
   endtask

   task automatic wait_done(input int max_cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < max_cycles && !seen; i++) begin
         @(negedge clk);
         if (msg_done) seen = 1'b1;
      end
      chk("msg_done_seen", int'(seen), 1);
   endtask

   always @(negedge clk) begin
      if (msg_done) done_cnt++;
      if (busy) begin
         busy_total++;
         busy_run++;
      end else begin
         if (busy_run != 0) last_run = busy_run;
         busy_run = 0;
      end
   end

   // UART monitor: samples each negedge, checks every bit is held CPB cycles, scores each byte.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && tx == 1'b0) begin
            mon_ok = 1'b1; mon_abort = 1'b0; mon_byte = 8'h00; mon_prev = 1'b0;
            for (int k = 0; k < 10*CPB; k++) begin
               if (k > 0) @(negedge clk);
               if (!rst_n) begin
                  mon_abort = 1'b1;
                  break;
               end
               if (k % CPB == 0) begin
                  mon_prev = tx;
                  if (k == 0 && tx != 1'b0) mon_ok = 1'b0;
                  if (k == 9*CPB && tx != 1'b1) mon_ok = 1'b0;
                  if (k >= CPB && k < 9*CPB) mon_byte[k/CPB - 1] = tx;
               end else if (tx != mon_prev) begin
                  mon_ok = 1'b0;
               end
            end
            if (!mon_abort) begin
               mon_frames++;
               chk("frame_shape", int'(mon_ok), 1);
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_byte: got 0x%02h expected none", mon_byte);
               end else begin
                  mon_exp = exp_q.pop_front();
                  chk("byte", int'(mon_byte), int'(mon_exp));
               end
            end
         end
      end
   end

   initial begin
      int d0, b0, f0;
      rst_n = 1'b0; status = 3'd0; resend = 1'b0;
      #12;
      chk("rst_tx", int'(tx), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(msg_done), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: quiet after reset
      repeat (500) @(posedge clk);
      #1;
      chk("quiet_tx", int'(tx), 1);
      chk("quiet_busy_cycles", busy_total, 0);
      chk("quiet_done", done_cnt, 0);
      chk("quiet_frames", mon_frames, 0);

      // 2: 000 -> 001, latency and message length
      push_msg({"OPEN", 8'h0D, 8'h0A});
      status = 3'd1;
      @(posedge clk); #1;
      chk("lat_e1_tx", int'(tx), 1);
      @(posedge clk); #1;
      chk("lat_e2_tx", int'(tx), 0);
      chk("lat_e2_busy", int'(busy), 1);
      wait_done(300);
      @(posedge clk); #1;
      chk("busy_len", last_run, 60*CPB);
      chk("done_count_open", done_cnt, 1);

      // 3: intermediate status collapsed into one follow-up
      d0 = done_cnt;
      push_msg({"IDLE", 8'h0D, 8'h0A});
      status = 3'd0;
      wait_done(300);
      @(posedge clk); #1;
      push_msg({"OPEN", 8'h0D, 8'h0A});
      push_msg({"ERR2", 8'h0D, 8'h0A});
      status = 3'd1;
      repeat (50) @(posedge clk);
      #1 status = 3'd2;
      repeat (50) @(posedge clk);
      #1 status = 3'd3;
      wait_done(300);
      @(negedge clk);
      chk("gap_idle_busy", int'(busy), 0);
      @(negedge clk);
      chk("gap_start_busy", int'(busy), 1);
      wait_done(300);
      repeat (300) @(posedge clk);
      #1;
      chk("coalesce_done_count", done_cnt - d0, 3);

      // 4: resend when idle, and resend during transmission
      d0 = done_cnt;
      push_msg({"LOCK", 8'h0D, 8'h0A});
      status = 3'd4;
      wait_done(300);
      @(posedge clk); #1;
      push_msg({"LOCK", 8'h0D, 8'h0A});
      resend = 1'b1;
      @(posedge clk); #1 resend = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      chk("resend_busy", int'(busy), 1);
      push_msg({"LOCK", 8'h0D, 8'h0A});
      resend = 1'b1;
      @(posedge clk); #1 resend = 1'b0;
      wait_done(300);
      wait_done(300);
      repeat (300) @(posedge clk);
      #1;
      chk("resend_done_count", done_cnt - d0, 3);

      // 5: unknown code
      push_msg({"????", 8'h0D, 8'h0A});
      status = 3'd7;
      wait_done(300);
      repeat (10) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);

      // 6: reset mid third byte aborts the message and stays silent afterwards
      push_msg({"IDLE", 8'h0D, 8'h0A});
      status = 3'd0;
      repeat (102) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_tx", int'(tx), 1);
      chk("abort_busy", int'(busy), 0);
      exp_q.delete();
      d0 = done_cnt; b0 = busy_total; f0 = mon_frames;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      chk("post_rst_done", done_cnt - d0, 0);
      chk("post_rst_busy", busy_total - b0, 0);
      chk("post_rst_frames", mon_frames - f0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
